// File: rtl/doodle_pkg.sv
// doodle_pkg: screen constants, coordinate types and motion states shared by the doodle blocks
package doodle_pkg;
    typedef logic [10:0] coord_x_t;
    typedef logic [9:0]  coord_y_t;
    typedef enum logic [1:0] {IDLE, RISE, FALL, DEAD} motion_state_e;
    localparam coord_x_t SCREEN_W = 11'd1024;
    localparam coord_y_t SCREEN_H = 10'd768;
    localparam coord_y_t DOODLE_H = 10'd80;
endpackage

// File: rtl/doodle_motion_if.sv
// doodle_motion_if: frame/control inputs and sprite position outputs of the doodle motion block
interface doodle_motion_if;
    import doodle_pkg::*;
    logic             frame_tick;
    logic             game_enable;
    logic             doodle_collision;
    logic [1:0][9:0]  ground;
    logic             btn_left;
    logic             btn_right;
    coord_x_t         doodle_x;
    coord_y_t         doodle_y;
    logic             doodle_fall_direction;
    logic             doodle_dead;
    logic             jump_start;
    modport master (
        output frame_tick, game_enable, doodle_collision, ground, btn_left, btn_right,
        input  doodle_x, doodle_y, doodle_fall_direction, doodle_dead, jump_start
    );
    modport slave (
        input  frame_tick, game_enable, doodle_collision, ground, btn_left, btn_right,
        output doodle_x, doodle_y, doodle_fall_direction, doodle_dead, jump_start
    );
endinterface

// File: rtl/doodle_motion_h_wrap_stepper.sv
// h_wrap_stepper: combinational next-x for one steering step with wrap across the screen width
module h_wrap_stepper
    import doodle_pkg::*;
#(
    parameter coord_x_t H_STEP = 11'd4
) (
    input  coord_x_t x,
    input  logic     btn_left,
    input  logic     btn_right,
    output coord_x_t x_next
);
    coord_x_t right;
    assign right = x + H_STEP;
    assign x_next = (btn_right && !btn_left) ? ((right >= SCREEN_W) ? right - SCREEN_W : right) :
                    (btn_left && !btn_right) ? ((x < H_STEP) ? x + SCREEN_W - H_STEP : x - H_STEP) :
                    x;
endmodule

// File: rtl/doodle_motion.sv
// doodle_motion: per-frame jump/fall physics and wrapped steering for the doodle sprite.
// Define DOODLE_SCREEN_FLOOR_EN to bounce off the bottom edge instead of dying.
module doodle_motion
    import doodle_pkg::*;
#(
    parameter logic [5:0] JUMP_V     = 6'd20,
    parameter logic [5:0] GRAVITY    = 6'd1,
    parameter logic [5:0] MAX_FALL_V = 6'd24,
    parameter coord_x_t   H_STEP     = 11'd4,
    parameter coord_x_t   START_X    = 11'd480,
    parameter coord_y_t   START_Y    = 10'd600
) (
    input logic           clk,
    input logic           rst,
    doodle_motion_if.slave bus
);
    motion_state_e st;
    logic [5:0]    v;
    logic [5:0]    v_dn;
    logic [5:0]    v_up;
    logic [10:0]   y_sum;
    coord_y_t      y_rise;
    coord_x_t      x_step;
    logic          ground_x_unused;

    h_wrap_stepper #(.H_STEP(H_STEP)) u_hw (
        .x(bus.doodle_x),
        .btn_left(bus.btn_left),
        .btn_right(bus.btn_right),
        .x_next(x_step)
    );

    assign ground_x_unused = ^bus.ground[1];
    assign y_sum  = 11'(bus.doodle_y) + 11'(v);
    assign y_rise = (bus.doodle_y >= 10'(v)) ? bus.doodle_y - 10'(v) : '0;
    assign v_dn   = (v > GRAVITY) ? v - GRAVITY : '0;
    assign v_up   = (v + GRAVITY >= MAX_FALL_V) ? MAX_FALL_V : v + GRAVITY;

    // Collision wins over a coincident tick, so the FALL branch tests it first.
    always_ff @(posedge clk) begin
        if (rst) begin
            st                        <= IDLE;
            v                         <= '0;
            bus.doodle_x              <= START_X;
            bus.doodle_y              <= START_Y;
            bus.doodle_fall_direction <= 1'b0;
            bus.doodle_dead           <= 1'b0;
            bus.jump_start            <= 1'b0;
        end else begin
            bus.jump_start <= 1'b0;
            case (st)
                IDLE: if (bus.frame_tick && bus.game_enable) begin
                    st             <= RISE;
                    v              <= JUMP_V;
                    bus.jump_start <= 1'b1;
                end
                RISE: if (bus.frame_tick) begin
                    bus.doodle_y <= y_rise;
                    bus.doodle_x <= x_step;
                    v            <= v_dn;
                    if (v_dn == '0) begin
                        st                        <= FALL;
                        bus.doodle_fall_direction <= 1'b1;
                    end
                end
                FALL: if (bus.doodle_collision) begin
                    st                        <= RISE;
                    v                         <= JUMP_V;
                    bus.doodle_y              <= bus.ground[0] - DOODLE_H;
                    bus.doodle_fall_direction <= 1'b0;
                    bus.jump_start            <= 1'b1;
                end else if (bus.frame_tick) begin
                    if (y_sum >= 11'(SCREEN_H)) begin
`ifdef DOODLE_SCREEN_FLOOR_EN
                        st                        <= RISE;
                        v                         <= JUMP_V;
                        bus.doodle_y              <= SCREEN_H - DOODLE_H;
                        bus.doodle_fall_direction <= 1'b0;
                        bus.jump_start            <= 1'b1;
`else
                        st              <= DEAD;
                        bus.doodle_dead <= 1'b1;
`endif
                    end else begin
                        bus.doodle_y <= y_sum[9:0];
                        bus.doodle_x <= x_step;
                        v            <= v_up;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/doodle_motion.md
Name: doodle_motion

Overview:
- Moves the doodle each frame: vertical jump/fall physics and horizontal steering with screen wrap.
- Sits directly downstream of the collision observer. It consumes `doodle_collision` and `ground`.
- It produces `doodle_x`, `doodle_y` and `doodle_fall_direction`, which feed back into the collision observer, renderer and scroller.
- All physics steps happen on `frame_tick`. Landing response happens on any clk.

Parameters:
- SCREEN_W, 1024, horizontal wrap modulus in px.
- SCREEN_H, 768, bottom edge; falling past it kills the doodle.
- DOODLE_H, 80, sprite height; landing snaps `doodle_y` to ground_y - DOODLE_H.
- JUMP_V, 20, initial upward speed in px/frame.
- GRAVITY, 1, speed change per frame.
- MAX_FALL_V, 24, fall speed cap in px/frame.
- H_STEP, 4, horizontal px per frame.
- START_X, 480, reset x.
- START_Y, 600, reset y.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- game_enable  in  1  leaves IDLE when high
- doodle_collision  in  1  registered landing hit from the collision observer
- ground  in  [1:0][9:0]  landed platform: [0]=y, [1]=x
- btn_left  in  1  steer left, level
- btn_right  in  1  steer right, level
- doodle_x  out  11  sprite left x, 0..SCREEN_W-1
- doodle_y  out  10  sprite top y
- doodle_fall_direction  out  1  1 while falling
- doodle_dead  out  1  sticky death flag
- jump_start  out  1  one-cycle pulse on every jump launch

Behaviour:
- Reset values:
  - doodle_x=START_X, doodle_y=START_Y.
  - Internal velocity v (6-bit unsigned magnitude) = 0.
  - State IDLE.
  - doodle_fall_direction=0, doodle_dead=0, jump_start=0.
  - Reset mid-operation restores all of these on the next edge.
- States:
  - IDLE:
    - frame_tick & game_enable -> RISE with v=JUMP_V and jump_start pulse.
    - The position update is skipped on that tick.
  - RISE, on each frame_tick:
    - y = (y>=v) ? y-v : 0 (saturate at 0).
    - Then v = v-GRAVITY, floored at 0.
    - v reaching 0 -> FALL with fall_direction=1 on the same edge.
  - FALL, on each frame_tick:
    - If y+v >= SCREEN_H (computed 11-bit, no wrap) -> DEAD.
    - Otherwise y = y+v, then v = min(v+GRAVITY, MAX_FALL_V).
  - Landing, in FALL, on any cycle with doodle_collision=1:
    - Next edge: y = ground[0]-DOODLE_H, v=JUMP_V, state RISE.
    - doodle_fall_direction=0, jump_start=1.
    - Collision beats a coincident frame_tick; that tick's physics step is discarded.
  - DEAD:
    - doodle_dead=1; position is frozen.
    - Leaves only on rst.
- doodle_collision is ignored in IDLE, RISE and DEAD. This covers the observer's one-cycle-late repeat after launch.
- Horizontal, on frame_tick in RISE or FALL:
  - Right only: x+H_STEP; if >= SCREEN_W, subtract SCREEN_W.
  - Left only: if x < H_STEP, x+SCREEN_W-H_STEP; else x-H_STEP.
  - Both or neither pressed: no move.
  - No horizontal motion in IDLE or DEAD.
- Timing:
  - jump_start is high for exactly one cycle.
  - Outputs are registered; latency is one clk from a tick or collision to the new position.

Optional Feature:
- Macro DOODLE_SCREEN_FLOOR_EN.
- Defined (attract/debug mode): the FALL bottom-edge condition does not kill. Instead y = SCREEN_H-DOODLE_H, v=JUMP_V, state RISE, jump_start pulse. doodle_dead stays 0.
- Undefined: behaviour as described above (DEAD).

Decomposition:
- Package doodle_pkg holds:
  - Screen constants SCREEN_W, SCREEN_H, DOODLE_H.
  - Coordinate typedefs coord_x_t (logic [10:0]) and coord_y_t (logic [9:0]).
  - The motion state enum motion_state_e {IDLE, RISE, FALL, DEAD}.
- One sub-module: h_wrap_stepper, combinational next-x from x, btn_left, btn_right, H_STEP, SCREEN_W.

Test Plan:
- Jump arc: reset, game_enable=1, one frame_tick, then 20 ticks with no collision -> jump_start pulses once; y=390 and state FALL with fall_direction=1 after the 20th tick.
- Landing: in FALL, assert doodle_collision with ground[0]=500 -> next cycle y=420, v=20, fall_direction=0, jump_start=1. A repeat collision on the following cycle is ignored.
- Collision plus coincident frame_tick -> the landing result is applied and y shows no fall step.
- Wrap right: x=1020, btn_right, one tick -> x=0.
- Wrap left: x=2, btn_left, one tick -> x=1022. Both buttons pressed -> x unchanged.
- Death: FALL with y=760 and v=10, one tick -> doodle_dead=1 and x/y frozen; with DOODLE_SCREEN_FLOOR_EN defined -> y=688, RISE, jump_start=1.
- Reset mid-FALL -> next edge x=480, y=600, IDLE, all flags 0.
